// File: rtl/dmem_mmio_bridge_pkg.sv
// Shared register map and constants for the data-memory / MMIO bridge.
package dmem_mmio_bridge_pkg;

    localparam logic [31:0] MMIO_BASE_DEFAULT = 32'h0000_0100;
    localparam int unsigned NUM_GPIO_REGS     = 7;
    localparam int unsigned ERR_WRITE_BIT     = 0;

    typedef enum logic [2:0] {
        REG_LED       = 3'd0,
        REG_MODE      = 3'd1,
        REG_SW_STATE  = 3'd2,
        REG_SW_EDGE   = 3'd3,
        REG_BLINK_DIV = 3'd4,
        REG_ERR       = 3'd5,
        REG_ERR_ADDR  = 3'd6
    } gpio_reg_e;

endpackage

// File: rtl/dmem_mmio_bridge_gpio_blink_timer.sv
// Blink prescaler: down-counter that reloads from BLINK_DIV and toggles the blink phase at zero.
module dmem_mmio_bridge_gpio_blink_timer #(
    parameter int unsigned DIV_W = 27
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             div_we,
    input  logic [DIV_W-1:0] div_wdata,
    output logic [DIV_W-1:0] blink_div,
    output logic             phase
);

    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             phase_q, phase_d;

    always_comb begin
        div_d   = div_q;
        cnt_d   = cnt_q - 1'b1;
        phase_d = phase_q;
        if (div_we) begin
            // a new divider restarts the count immediately but keeps the current phase
            div_d = div_wdata;
            cnt_d = div_wdata;
        end else if (cnt_q == '0) begin
            cnt_d   = div_q;
            phase_d = ~phase_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_q   <= '1;
            cnt_q   <= '1;
            phase_q <= 1'b0;
        end else begin
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign blink_div = div_q;
    assign phase     = phase_q;

endmodule

// File: rtl/dmem_mmio_bridge.sv
// Data RAM plus GPIO register window (LEDs with blink, switches with edge capture, write-error log).
module dmem_mmio_bridge
    import dmem_mmio_bridge_pkg::*;
#(
    parameter int unsigned RAM_DEPTH        = 16,
    parameter logic [31:0] MMIO_BASE        = MMIO_BASE_DEFAULT,
    parameter int unsigned NUM_LEDS         = 4,
    parameter int unsigned NUM_SW           = 4,
    parameter int unsigned DIV_W            = 27,
    parameter bit          CLEAR_RAM_ON_RST = 1'b1
) (
    input  logic                CK_REF,
    input  logic                RST_N,
    input  logic [31:0]         MEM_ACCESS_ADDRESS_BUS,
    input  logic [31:0]         MEM_ACCESS_DATA_OUT_BUS,
    input  logic                MEM_ACCESS_READ_WRN,
    output logic [31:0]         MEM_ACCESS_DATA_IN_BUS,
    input  logic [NUM_SW-1:0]   SW_IN,
    output logic [NUM_LEDS-1:0] LED_OUT,
    output logic                BUS_ERR
);

    localparam int unsigned RAM_AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;

    logic [31:0]         mem_q [RAM_DEPTH];
    logic [NUM_LEDS-1:0] led_reg_q, led_reg_d, mode_q, mode_d, led_q, led_d;
    logic [NUM_SW-1:0]   sync1_q, sync2_q, sync3_q, sw_edge_q, sw_edge_d, sw_clr;
    logic                err_q, err_d, err_clr;
    logic [31:0]         err_addr_q, err_addr_d;

    logic                wr_en, is_ram, is_mmio, bad_wr, div_we, phase;
    logic [31:0]         reg_off;
    gpio_reg_e           reg_sel;
    logic [RAM_AW-1:0]   ram_idx;
    logic [DIV_W-1:0]    blink_div;

    // Full 32-bit compares on both windows so no upper-address aliasing exists.
    assign wr_en   = ~MEM_ACCESS_READ_WRN;
    assign reg_off = MEM_ACCESS_ADDRESS_BUS - MMIO_BASE;
    assign is_ram  = MEM_ACCESS_ADDRESS_BUS < RAM_DEPTH;
    assign is_mmio = (MEM_ACCESS_ADDRESS_BUS >= MMIO_BASE) && (reg_off < NUM_GPIO_REGS);
    assign reg_sel = gpio_reg_e'(reg_off[2:0]);
    assign ram_idx = MEM_ACCESS_ADDRESS_BUS[RAM_AW-1:0];
    assign bad_wr  = wr_en & ~is_ram & ~is_mmio;
    assign div_we  = wr_en & is_mmio & (reg_sel == REG_BLINK_DIV);

    dmem_mmio_bridge_gpio_blink_timer #(
        .DIV_W (DIV_W)
    ) u_blink (
        .clk       (CK_REF),
        .rst_n     (RST_N),
        .div_we    (div_we),
        .div_wdata (MEM_ACCESS_DATA_OUT_BUS[DIV_W-1:0]),
        .blink_div (blink_div),
        .phase     (phase)
    );

    always_comb begin
        led_reg_d  = led_reg_q;
        mode_d     = mode_q;
        sw_clr     = '0;
        err_clr    = 1'b0;
        err_addr_d = err_addr_q;
        if (wr_en && is_mmio) begin
            case (reg_sel)
                REG_LED:     led_reg_d = MEM_ACCESS_DATA_OUT_BUS[NUM_LEDS-1:0];
                REG_MODE:    mode_d    = MEM_ACCESS_DATA_OUT_BUS[NUM_LEDS-1:0];
                REG_SW_EDGE: sw_clr    = MEM_ACCESS_DATA_OUT_BUS[NUM_SW-1:0];
                REG_ERR:     err_clr   = MEM_ACCESS_DATA_OUT_BUS[ERR_WRITE_BIT];
                default:     ;
            endcase
        end
        sw_edge_d = (sw_edge_q & ~sw_clr) | (sync2_q & ~sync3_q);
        if (bad_wr && (!err_q || err_clr)) begin
            err_addr_d = MEM_ACCESS_ADDRESS_BUS;
        end
        err_d = (err_q & ~err_clr) | bad_wr;
        for (int unsigned i = 0; i < NUM_LEDS; i++) begin
            led_d[i] = led_reg_q[i] & (mode_q[i] ? phase : 1'b1);
        end
    end

    always_ff @(posedge CK_REF) begin
        if (!RST_N) begin
            led_reg_q  <= '0;
            mode_q     <= '0;
            led_q      <= '0;
            sync1_q    <= '0;
            sync2_q    <= '0;
            sync3_q    <= '0;
            sw_edge_q  <= '0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else begin
            led_reg_q  <= led_reg_d;
            mode_q     <= mode_d;
            led_q      <= led_d;
            sync1_q    <= SW_IN;
            sync2_q    <= sync1_q;
            sync3_q    <= sync2_q;
            sw_edge_q  <= sw_edge_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
        end
    end

    always_ff @(posedge CK_REF) begin
        if (!RST_N) begin
            if (CLEAR_RAM_ON_RST) begin
                for (int unsigned i = 0; i < RAM_DEPTH; i++) begin
                    mem_q[i] <= '0;
                end
            end
        end else if (wr_en && is_ram) begin
            mem_q[ram_idx] <= MEM_ACCESS_DATA_OUT_BUS;
        end
    end

    always_comb begin
        MEM_ACCESS_DATA_IN_BUS = '0;
        if (is_ram) begin
            MEM_ACCESS_DATA_IN_BUS = mem_q[ram_idx];
        end else if (is_mmio) begin
            case (reg_sel)
                REG_LED:       MEM_ACCESS_DATA_IN_BUS = 32'(led_reg_q);
                REG_MODE:      MEM_ACCESS_DATA_IN_BUS = 32'(mode_q);
                REG_SW_STATE:  MEM_ACCESS_DATA_IN_BUS = 32'(sync2_q);
                REG_SW_EDGE:   MEM_ACCESS_DATA_IN_BUS = 32'(sw_edge_q);
                REG_BLINK_DIV: MEM_ACCESS_DATA_IN_BUS = 32'(blink_div);
                REG_ERR:       MEM_ACCESS_DATA_IN_BUS[ERR_WRITE_BIT] = err_q;
                REG_ERR_ADDR:  MEM_ACCESS_DATA_IN_BUS = err_addr_q;
                default:       MEM_ACCESS_DATA_IN_BUS = '0;
            endcase
        end
    end

    assign LED_OUT = led_q;
    assign BUS_ERR = err_q;

endmodule
